// File: rtl/tft_spi_tx.sv
// ---------------------------------------------------------------------------
// tft_spi_tx
//
// Byte-level SPI (mode 0, MSB first) transmitter that owns the TFT panel pins.
// A drawing engine strobes one command/data byte at a time. The block then
// clocks the byte out, keeps chip-select low for a short idle window so that
// back-to-back bytes share one CS assertion, and optionally sequences the
// panel hardware reset after rst.
//
// Build option: define TFT_RST_SEQ_EN to include the panel reset sequence
// (RST_LOW -> RST_WAIT -> IDLE). Without it, lcd_rst_n is tied high and the
// block goes straight to IDLE after rst.
//
// Parameters
//   CLK_DIV         SCK half-period in clk cycles (>=1)
//   CS_IDLE_CYCLES  idle cycles after a byte before CS deasserts (>=1)
//   RST_LOW_CYCLES  lcd_rst_n low time (reset sequence only)
//   RST_WAIT_CYCLES wait after lcd_rst_n rises (reset sequence only)
//
// Ports
//   clk, rst         system clock, synchronous active-high reset
//   enable           clock enable; everything holds while low
//   tft_transmit     byte strobe, accepted only while tft_busy=0
//   tft_dc, tft_data D/C flag and byte captured with the strobe
//   tft_busy         transmitter occupied
//   tft_overrun      sticky: a strobe arrived while busy
//   spi_sck/mosi/cs_n/dc, lcd_rst_n  panel pins
// ---------------------------------------------------------------------------
module tft_spi_tx #(
  parameter int CLK_DIV         = 2,
  parameter int CS_IDLE_CYCLES  = 8,
  parameter int RST_LOW_CYCLES  = 1000,
  parameter int RST_WAIT_CYCLES = 150000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       tft_transmit,
  input  logic       tft_dc,
  input  logic [7:0] tft_data,
  output logic       tft_busy,
  output logic       tft_overrun,
  output logic       spi_sck,
  output logic       spi_mosi,
  output logic       spi_cs_n,
  output logic       spi_dc,
  output logic       lcd_rst_n
);

  localparam int DIV_W  = $clog2(CLK_DIV + 1);
  localparam int HOLD_W = $clog2(CS_IDLE_CYCLES + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CS_IDLE_CYCLES - 1);

  generate
    if (CLK_DIV < 1 || CS_IDLE_CYCLES < 1 || RST_LOW_CYCLES < 1 || RST_WAIT_CYCLES < 1) begin : g_param_check
      $error("tft_spi_tx: all cycle-count parameters must be >= 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    RST_LOW,
    RST_WAIT,
    IDLE,
    SHIFT,
    HOLD
  } state_t;

`ifdef TFT_RST_SEQ_EN
  localparam int SEQ_MAX = (RST_LOW_CYCLES > RST_WAIT_CYCLES) ? RST_LOW_CYCLES : RST_WAIT_CYCLES;
  localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
  localparam logic [SEQ_W-1:0] LOW_LAST  = SEQ_W'(RST_LOW_CYCLES - 1);
  localparam logic [SEQ_W-1:0] WAIT_LAST = SEQ_W'(RST_WAIT_CYCLES - 1);
  localparam state_t RESET_STATE = RST_LOW;
  localparam logic   RESET_BUSY  = 1'b1;
`else
  localparam state_t RESET_STATE = IDLE;
  localparam logic   RESET_BUSY  = 1'b0;
`endif

  state_t            state_reg, state_next;
  logic [DIV_W-1:0]  div_cnt_reg, div_cnt_next;
  logic [2:0]        bit_cnt_reg, bit_cnt_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  // Holds only the bits not yet presented on MOSI; bit 7 goes out directly.
  logic [6:0]        shift_reg, shift_next;
  logic              sck_reg, sck_next;
  logic              mosi_reg, mosi_next;
  logic              cs_n_reg, cs_n_next;
  logic              dc_reg, dc_next;
  logic              busy_reg, busy_next;
  logic              overrun_reg, overrun_next;
`ifdef TFT_RST_SEQ_EN
  logic [SEQ_W-1:0]  seq_cnt_reg, seq_cnt_next;
  logic              lcd_rst_n_reg, lcd_rst_n_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= RESET_STATE;
      div_cnt_reg   <= '0;
      bit_cnt_reg   <= '0;
      hold_cnt_reg  <= '0;
      shift_reg     <= '0;
      sck_reg       <= 1'b0;
      mosi_reg      <= 1'b0;
      cs_n_reg      <= 1'b1;
      dc_reg        <= 1'b0;
      busy_reg      <= RESET_BUSY;
      overrun_reg   <= 1'b0;
`ifdef TFT_RST_SEQ_EN
      seq_cnt_reg   <= '0;
      lcd_rst_n_reg <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      div_cnt_reg   <= div_cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      hold_cnt_reg  <= hold_cnt_next;
      shift_reg     <= shift_next;
      sck_reg       <= sck_next;
      mosi_reg      <= mosi_next;
      cs_n_reg      <= cs_n_next;
      dc_reg        <= dc_next;
      busy_reg      <= busy_next;
      overrun_reg   <= overrun_next;
`ifdef TFT_RST_SEQ_EN
      seq_cnt_reg   <= seq_cnt_next;
      lcd_rst_n_reg <= lcd_rst_n_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    div_cnt_next   = div_cnt_reg;
    bit_cnt_next   = bit_cnt_reg;
    hold_cnt_next  = hold_cnt_reg;
    shift_next     = shift_reg;
    sck_next       = sck_reg;
    mosi_next      = mosi_reg;
    cs_n_next      = cs_n_reg;
    dc_next        = dc_reg;
    busy_next      = busy_reg;
    overrun_next   = overrun_reg;
`ifdef TFT_RST_SEQ_EN
    seq_cnt_next   = seq_cnt_reg;
    lcd_rst_n_next = lcd_rst_n_reg;
`endif

    if (enable) begin
      // A strobe while busy is dropped; the running transfer is untouched.
      if (tft_transmit && busy_reg) begin
        overrun_next = 1'b1;
      end

      case (state_reg)
`ifdef TFT_RST_SEQ_EN
        RST_LOW: begin
          if (seq_cnt_reg == LOW_LAST) begin
            seq_cnt_next   = '0;
            lcd_rst_n_next = 1'b1;
            state_next     = RST_WAIT;
          end else begin
            seq_cnt_next = seq_cnt_reg + 1'b1;
          end
        end

        RST_WAIT: begin
          if (seq_cnt_reg == WAIT_LAST) begin
            seq_cnt_next = '0;
            busy_next    = 1'b0;
            state_next   = IDLE;
          end else begin
            seq_cnt_next = seq_cnt_reg + 1'b1;
          end
        end
`endif

        IDLE, HOLD: begin
          if (tft_transmit) begin
            // Accept: first bit goes straight to MOSI so it is set up a full
            // half-period before the first SCK rise.
            shift_next    = tft_data[6:0];
            mosi_next     = tft_data[7];
            dc_next       = tft_dc;
            cs_n_next     = 1'b0;
            busy_next     = 1'b1;
            sck_next      = 1'b0;
            div_cnt_next  = '0;
            bit_cnt_next  = '0;
            hold_cnt_next = '0;
            state_next    = SHIFT;
          end else if (state_reg == HOLD) begin
            if (hold_cnt_reg == HOLD_LAST) begin
              hold_cnt_next = '0;
              cs_n_next     = 1'b1;
              state_next    = IDLE;
            end else begin
              hold_cnt_next = hold_cnt_reg + 1'b1;
            end
          end
        end

        SHIFT: begin
          if (div_cnt_reg == DIV_LAST) begin
            div_cnt_next = '0;
            if (!sck_reg) begin
              sck_next = 1'b1;
            end else begin
              sck_next = 1'b0;
              if (bit_cnt_reg == 3'd7) begin
                // Last high phase done: release the producer on the same edge.
                busy_next     = 1'b0;
                hold_cnt_next = '0;
                state_next    = HOLD;
              end else begin
                mosi_next    = shift_reg[6];
                shift_next   = {shift_reg[5:0], 1'b0};
                bit_cnt_next = bit_cnt_reg + 1'b1;
              end
            end
          end else begin
            div_cnt_next = div_cnt_reg + 1'b1;
          end
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign tft_busy    = busy_reg;
  assign tft_overrun = overrun_reg;
  assign spi_sck     = sck_reg;
  assign spi_mosi    = mosi_reg;
  assign spi_cs_n    = cs_n_reg;
  assign spi_dc      = dc_reg;
`ifdef TFT_RST_SEQ_EN
  assign lcd_rst_n   = lcd_rst_n_reg;
`else
  assign lcd_rst_n   = 1'b1;
`endif

endmodule
